// File: rtl/flag_ctrl.sv
// Architectural flag register {N,V,C,Z}: ALU update pipe, load/clear, interrupt
// shadow copy, and a branch evaluator that waits for in-flight ALU updates.
module flag_ctrl #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_carry,
  input  logic          alu_ovf,
  input  logic [3:0]    upd_mask,
  input  logic          ld_valid,
  input  logic [3:0]    ld_data,
  input  logic [3:0]    clr_req,
  input  logic          irq_save,
  input  logic          irq_restore,
  input  logic          br_req,
  input  logic [2:0]    br_cond,
  output logic [3:0]    flags,
  output logic          br_busy,
  output logic          br_valid,
  output logic          br_taken
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2
  } br_state_t;

  br_state_t   state_r;
  logic [2:0]  cond_r;
  logic        br_valid_r;
  logic        br_taken_r;

  logic [3:0]  flags_r;
  logic [3:0]  shadow_r;
  logic        shadow_valid_r;
  logic        pipe_valid_r;
  logic [3:0]  pipe_flags_r;
  logic [3:0]  pipe_mask_r;

  logic [3:0]  alu_flags_s;
  logic [3:0]  flags_nxt_s;
  logic        restore_s;
  logic        pending_s;

  // Branch condition decode over a {N,V,C,Z} flag vector.
  function automatic logic cond_eval(input logic [2:0] cond, input logic [3:0] f);
    logic r;
    case (cond)
      3'b000:  r = 1'b1;
      3'b001:  r = f[0];
      3'b010:  r = ~f[0];
      3'b011:  r = f[1];
      3'b100:  r = ~f[1];
      3'b101:  r = f[3];
      3'b110:  r = f[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign alu_flags_s = {alu_result[DW-1], alu_ovf, alu_carry, (alu_result == {DW{1'b0}})};
  // A save in the same cycle suppresses the restore entirely.
  assign restore_s   = irq_restore & shadow_valid_r & ~irq_save;
  assign pending_s   = pipe_valid_r | alu_valid;

  // Per-bit next flag value: clear > restore > load > pipe write > hold.
  always_comb begin
    flags_nxt_s = flags_r;
    for (int i = 0; i < 4; i++) begin
      if (clr_req[i]) begin
        flags_nxt_s[i] = 1'b0;
      end else if (restore_s) begin
        flags_nxt_s[i] = shadow_r[i];
      end else if (ld_valid) begin
        flags_nxt_s[i] = ld_data[i];
      end else if (pipe_valid_r && pipe_mask_r[i]) begin
        flags_nxt_s[i] = pipe_flags_r[i];
      end else begin
        flags_nxt_s[i] = flags_r[i];
      end
    end
  end

  // Flag register, ALU capture pipe and interrupt shadow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_r        <= 4'b0000;
      shadow_r       <= 4'b0000;
      shadow_valid_r <= 1'b0;
      pipe_valid_r   <= 1'b0;
      pipe_flags_r   <= 4'b0000;
      pipe_mask_r    <= 4'b0000;
    end else begin
      flags_r      <= flags_nxt_s;
      pipe_valid_r <= alu_valid;
      if (alu_valid) begin
        pipe_flags_r <= alu_flags_s;
        pipe_mask_r  <= upd_mask;
      end
      if (irq_save) begin
        shadow_r       <= flags_r;
        shadow_valid_r <= 1'b1;
      end else if (restore_s) begin
        shadow_valid_r <= 1'b0;
      end
    end
  end

  // Branch FSM; the result is evaluated on the flag value that will be visible
  // during RESOLVE, so br_taken stays a plain register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cond_r     <= 3'b000;
      br_valid_r <= 1'b0;
      br_taken_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          br_valid_r <= 1'b0;
          br_taken_r <= 1'b0;
          if (br_req) begin
            cond_r <= br_cond;
            if (!pending_s) begin
              state_r    <= ST_RESOLVE;
              br_valid_r <= 1'b1;
              br_taken_r <= cond_eval(br_cond, flags_nxt_s);
            end else begin
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!pending_s) begin
            state_r    <= ST_RESOLVE;
            br_valid_r <= 1'b1;
            br_taken_r <= cond_eval(cond_r, flags_nxt_s);
          end
        end
        ST_RESOLVE: begin
          state_r    <= ST_IDLE;
          br_valid_r <= 1'b0;
          br_taken_r <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          br_valid_r <= 1'b0;
          br_taken_r <= 1'b0;
        end
      endcase
    end
  end

  assign flags    = flags_r;
  assign br_busy  = (state_r != ST_IDLE);
  assign br_valid = br_valid_r;
  assign br_taken = br_taken_r;

endmodule

// File: tb/tb_flag_ctrl.sv
// Scoreboard bench for flag_ctrl: a reference model pushes the expected outputs
// after every edge, a monitor pops and compares them; directed scenarios plus random.
module tb_flag_ctrl;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          alu_valid;
  logic [DW-1:0] alu_result;
  logic          alu_carry;
  logic          alu_ovf;
  logic [3:0]    upd_mask;
  logic          ld_valid;
  logic [3:0]    ld_data;
  logic [3:0]    clr_req;
  logic          irq_save;
  logic          irq_restore;
  logic          br_req;
  logic [2:0]    br_cond;
  logic [3:0]    flags;
  logic          br_busy;
  logic          br_valid;
  logic          br_taken;

  flag_ctrl #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_ovf(alu_ovf), .upd_mask(upd_mask),
    .ld_valid(ld_valid), .ld_data(ld_data), .clr_req(clr_req),
    .irq_save(irq_save), .irq_restore(irq_restore), .br_req(br_req),
    .br_cond(br_cond), .flags(flags), .br_busy(br_busy),
    .br_valid(br_valid), .br_taken(br_taken)
  );

  typedef struct {
    logic [3:0] fl;
    logic       bv;
    logic       bt;
    logic       busy;
  } exp_t;

  typedef struct {
    logic [3:0] fl;
    logic [3:0] mask;
  } upd_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic taken_of(input logic [2:0] cond, input logic [3:0] f);
    // f = {N,V,C,Z}
    case (cond)
      3'd0:    return 1'b1;
      3'd1:    return f[0] == 1'b1;
      3'd2:    return f[0] == 1'b0;
      3'd3:    return f[1] == 1'b1;
      3'd4:    return f[1] == 1'b0;
      3'd5:    return f[3] == 1'b1;
      3'd6:    return f[2] == 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: ALU updates are queued and land one edge later; the flag
  // value is built by layering sources from lowest to highest priority.
  initial begin
    logic [3:0] m_flags, m_shadow, nf;
    logic       m_sv, m_busy, m_show, pend, rest;
    logic [2:0] m_cond;
    upd_t       pq[$];
    upd_t       e;
    exp_t       x;
    m_flags = 4'd0; m_shadow = 4'd0; m_sv = 1'b0;
    m_busy = 1'b0; m_show = 1'b0; m_cond = 3'd0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_flags = 4'd0; m_shadow = 4'd0; m_sv = 1'b0;
        m_busy = 1'b0; m_show = 1'b0; m_cond = 3'd0;
        pq.delete();
      end else begin
        pend = (pq.size() != 0);
        if (m_show) begin
          m_show = 1'b0;
          m_busy = 1'b0;
        end else if (m_busy) begin
          if (!pend && !alu_valid) m_show = 1'b1;
        end else if (br_req) begin
          m_busy = 1'b1;
          m_cond = br_cond;
          if (!pend && !alu_valid) m_show = 1'b1;
        end
        nf = m_flags;
        if (pend) begin
          e  = pq.pop_front();
          nf = (nf & ~e.mask) | (e.fl & e.mask);
        end
        if (ld_valid) nf = ld_data;
        rest = irq_restore && m_sv && !irq_save;
        if (rest) nf = m_shadow;
        nf = nf & ~clr_req;
        if (irq_save) begin
          m_shadow = m_flags;
          m_sv     = 1'b1;
        end else if (rest) begin
          m_sv = 1'b0;
        end
        m_flags = nf;
        if (alu_valid) begin
          e.fl   = {alu_result[DW-1], alu_ovf, alu_carry, (alu_result == 16'd0)};
          e.mask = upd_mask;
          pq.push_back(e);
        end
      end
      x.fl   = m_flags;
      x.bv   = m_show;
      x.bt   = m_show ? taken_of(m_cond, m_flags) : 1'b0;
      x.busy = m_busy;
      exp_q.push_back(x);
    end
  end

  // Monitor: one expected record per edge, compared just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        x = exp_q.pop_front();
        chk("sb_flags", {28'd0, flags}, {28'd0, x.fl});
        chk("sb_br_valid", {31'd0, br_valid}, {31'd0, x.bv});
        chk("sb_br_taken", {31'd0, br_taken}, {31'd0, x.bt});
        chk("sb_br_busy", {31'd0, br_busy}, {31'd0, x.busy});
      end
    end
  end

  task automatic idle();
    rst_n = 1'b1; alu_valid = 1'b0; alu_result = 16'd0; alu_carry = 1'b0;
    alu_ovf = 1'b0; upd_mask = 4'd0; ld_valid = 1'b0; ld_data = 4'd0;
    clr_req = 4'd0; irq_save = 1'b0; irq_restore = 1'b0; br_req = 1'b0;
    br_cond = 3'd0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) cyc();
    chk("reset_flags", {28'd0, flags}, 32'd0);
    chk("reset_busy", {31'd0, br_busy}, 32'd0);
    chk("reset_br_valid", {31'd0, br_valid}, 32'd0);

    // ALU result 0 with carry, full mask: two-edge latency
    idle(); alu_valid = 1'b1; alu_result = 16'd0; alu_carry = 1'b1; upd_mask = 4'b1111;
    cyc(); idle();
    chk("alu_lat_edge_t", {28'd0, flags}, 32'd0);
    cyc();
    chk("alu_lat_edge_t1", {28'd0, flags}, 32'b0011);

    // Pipe write Z=1,V=1 with Z cleared on the same edge
    idle(); alu_valid = 1'b1; alu_result = 16'd0; alu_ovf = 1'b1; upd_mask = 4'b1111;
    cyc(); idle(); clr_req = 4'b0001;
    cyc(); idle();
    chk("clr_over_pipe", {28'd0, flags}, 32'b0100);

    // Save / load / restore / second restore
    ld_valid = 1'b1; ld_data = 4'b0101;
    cyc(); idle(); irq_save = 1'b1;
    cyc(); idle(); ld_valid = 1'b1; ld_data = 4'b1010;
    cyc(); idle();
    chk("ld_after_save", {28'd0, flags}, 32'b1010);
    irq_restore = 1'b1;
    cyc(); idle();
    chk("restore", {28'd0, flags}, 32'b0101);
    ld_valid = 1'b1; ld_data = 4'b0010;
    cyc(); idle(); irq_restore = 1'b1;
    cyc(); idle();
    chk("restore_twice", {28'd0, flags}, 32'b0010);

    // Branch on Z waits for an ALU op issued in the same cycle
    br_req = 1'b1; br_cond = 3'b001; alu_valid = 1'b1; alu_result = 16'd0; upd_mask = 4'b0001;
    cyc(); idle();
    chk("brw_busy", {31'd0, br_busy}, 32'd1);
    chk("brw_nvalid0", {31'd0, br_valid}, 32'd0);
    cyc();
    chk("brw_z_written", {28'd0, flags}, 32'b0011);
    chk("brw_nvalid1", {31'd0, br_valid}, 32'd0);
    cyc();
    chk("brw_valid", {31'd0, br_valid}, 32'd1);
    chk("brw_taken", {31'd0, br_taken}, 32'd1);
    cyc();
    chk("brw_done", {31'd0, br_valid}, 32'd0);

    // Never-branch from idle; request during RESOLVE is ignored
    br_req = 1'b1; br_cond = 3'b111;
    cyc();
    chk("brn_valid", {31'd0, br_valid}, 32'd1);
    chk("brn_taken", {31'd0, br_taken}, 32'd0);
    br_cond = 3'b000;
    cyc(); idle();
    chk("brn_ignored_busy", {31'd0, br_busy}, 32'd0);
    chk("brn_ignored_valid", {31'd0, br_valid}, 32'd0);

    // Reset while waiting with an update in the pipe
    br_req = 1'b1; br_cond = 3'b000; alu_valid = 1'b1; alu_result = 16'h8000; upd_mask = 4'b1111;
    cyc(); idle(); rst_n = 1'b0;
    cyc(); idle();
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_busy", {31'd0, br_busy}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rst_no_br_valid", {31'd0, br_valid}, 32'd0);
      chk("rst_flags_hold", {28'd0, flags}, 32'd0);
    end

    // Randomized traffic, checked by the scoreboard
    for (int n = 0; n < 4000; n++) begin
      idle();
      rst_n       = ($urandom_range(0, 99) != 0);
      alu_valid   = ($urandom_range(0, 1) == 1);
      alu_result  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      alu_carry   = ($urandom_range(0, 1) == 1);
      alu_ovf     = ($urandom_range(0, 1) == 1);
      upd_mask    = 4'($urandom);
      ld_valid    = ($urandom_range(0, 7) == 0);
      ld_data     = 4'($urandom);
      clr_req     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
      irq_save    = ($urandom_range(0, 7) == 0);
      irq_restore = ($urandom_range(0, 5) == 0);
      br_req      = ($urandom_range(0, 2) == 0);
      br_cond     = 3'($urandom);
      cyc();
    end

    idle();
    repeat (4) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
